// File: rtl/ns_merge_2to1.sv
// Two-input, one-output four-phase message merge with one buffer per input,
// round-robin output arbitration and per-input forwarded-message counters.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module ns_merge_2to1 #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE,
  parameter int CSZ = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [CSZ-1:0] cnt_0,
  output logic [CSZ-1:0] cnt_1
);

  localparam int MSZ = 2*ASZ + DSZ + RSZ;

  typedef enum logic {O_IDLE, O_BUSY} ostate_t;

  ostate_t        state_q, state_d;
  logic [MSZ-1:0] buf0_q, buf0_d, buf1_q, buf1_d, out_q, out_d;
  logic           full0_q, full0_d, full1_q, full1_d;
  logic           ack0_q, ack0_d, ack1_q, ack1_d;
  logic           oreq_q, oreq_d;
  logic           last_q, last_d;
  logic [CSZ-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           sel;

  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    out_d   = out_q;
    full0_d = full0_q;
    full1_d = full1_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    oreq_d  = oreq_q;
    last_d  = last_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    sel     = 1'b0;

    // Capture tests the registered full flag, so a buffer emptied by a grant
    // this edge only accepts a new message on the following edge.
    if (i0_req && !ack0_q && !full0_q) begin
      buf0_d  = {i0_src, i0_dst, i0_dat, i0_red};
      full0_d = 1'b1;
      ack0_d  = 1'b1;
    end else if (!i0_req && ack0_q) begin
      ack0_d = 1'b0;
    end

    if (i1_req && !ack1_q && !full1_q) begin
      buf1_d  = {i1_src, i1_dst, i1_dat, i1_red};
      full1_d = 1'b1;
      ack1_d  = 1'b1;
    end else if (!i1_req && ack1_q) begin
      ack1_d = 1'b0;
    end

    unique case (state_q)
      O_IDLE: begin
        if (!o0_ack && (full0_q || full1_q)) begin
          // On a tie the input that did not win last time is served.
          sel     = (full0_q && full1_q) ? ~last_q : full1_q;
          state_d = O_BUSY;
          oreq_d  = 1'b1;
          last_d  = sel;
          if (sel) begin
            out_d   = buf1_q;
            full1_d = 1'b0;
            cnt1_d  = cnt1_q + CSZ'(1);
          end else begin
            out_d   = buf0_q;
            full0_d = 1'b0;
            cnt0_d  = cnt0_q + CSZ'(1);
          end
        end
      end
      O_BUSY: begin
        if (o0_ack) begin
          oreq_d  = 1'b0;
          state_d = O_IDLE;
        end
      end
      default: state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= O_IDLE;
      buf0_q  <= '0;
      buf1_q  <= '0;
      out_q   <= '0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      oreq_q  <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      out_q   <= out_d;
      full0_q <= full0_d;
      full1_q <= full1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      oreq_q  <= oreq_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign {o0_src, o0_dst, o0_dat, o0_red} = out_q;
  assign o0_req = oreq_q;
  assign i0_ack = ack0_q;
  assign i1_ack = ack1_q;
  assign cnt_0  = cnt0_q;
  assign cnt_1  = cnt1_q;

endmodule

// File: tb/tb_ns_merge_2to1.sv
// Scoreboarded bench for ns_merge_2to1: per-source expected queues, a delayed-ack
// sink, and a second instance with 4-bit counters for the wrap case.
`timescale 1ns/1ps
module tb_ns_merge_2to1;
  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 4;

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  msg_t m0, m1;
  logic req0, req1, ack0, ack1, o_req, o_ack;
  msg_t o_msg;
  logic [7:0] cnt0, cnt1;
  logic w_ack0, w_ack1, w_req;
  msg_t w_msg;
  logic [3:0] w_cnt0, w_cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  int sink_delay = 0;
  msg_t q0[$], q1[$];
  int log_q[$];
  int acc0 = 0, acc1 = 0, fwd0 = 0, fwd1 = 0;
  logic [31:0] ecnt0 = 0, ecnt1 = 0;

  always #5 clk = ~clk;

  ns_merge_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i0_src(m0.src), .i0_dst(m0.dst), .i0_dat(m0.dat), .i0_red(m0.red),
    .i0_req(req0), .i0_ack(ack0),
    .i1_src(m1.src), .i1_dst(m1.dst), .i1_dat(m1.dat), .i1_red(m1.red),
    .i1_req(req1), .i1_ack(ack1),
    .o0_src(o_msg.src), .o0_dst(o_msg.dst), .o0_dat(o_msg.dat), .o0_red(o_msg.red),
    .o0_req(o_req), .o0_ack(o_ack),
    .cnt_0(cnt0), .cnt_1(cnt1)
  );

  ns_merge_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CSZ(4)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n),
    .i0_src(m0.src), .i0_dst(m0.dst), .i0_dat(m0.dat), .i0_red(m0.red),
    .i0_req(req0), .i0_ack(w_ack0),
    .i1_src(m1.src), .i1_dst(m1.dst), .i1_dat(m1.dat), .i1_red(m1.red),
    .i1_req(req1), .i1_ack(w_ack1),
    .o0_src(w_msg.src), .o0_dst(w_msg.dst), .o0_dat(w_msg.dat), .o0_red(w_msg.red),
    .o0_req(w_req), .o0_ack(o_ack),
    .cnt_0(w_cnt0), .cnt_1(w_cnt1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic msg_t mk(input int k, input logic [DSZ-1:0] dat);
    msg_t m;
    m.src = ASZ'(k);
    m.dst = dat[ASZ-1:0] ^ 8'hA5;
    m.red = dat[RSZ-1:0] ^ RSZ'(k + 3);
    m.dat = dat;
    return m;
  endfunction

  // Sink: acks sink_delay negedges after seeing o0_req, drops ack after req drops.
  initial begin
    int waited;
    o_ack = 1'b0;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        o_ack = 1'b0;
        waited = 0;
      end else if (o_req === 1'b1 && !o_ack) begin
        if (waited >= sink_delay) begin
          o_ack = 1'b1;
          waited = 0;
        end else waited++;
      end else if (o_req === 1'b0 && o_ack) begin
        o_ack = 1'b0;
      end
    end
  end

  // Output monitor: each o0_req rise is a new message, popped from its source queue.
  initial begin
    logic prev;
    msg_t exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (o_req === 1'b1 && !prev) begin
          if (o_msg.src === 8'd0 && q0.size() > 0) begin
            exp = q0.pop_front();
            fwd0++; ecnt0++; log_q.push_back(0);
          end else if (o_msg.src === 8'd1 && q1.size() > 0) begin
            exp = q1.pop_front();
            fwd1++; ecnt1++; log_q.push_back(1);
          end else begin
            exp = '0;
            check("unexpected_msg", 64'(o_msg), 64'hFFFF_FFFF_FFFF_FFFF);
          end
          check("out_msg", 64'(o_msg), 64'(exp));
          check("wrap_msg", 64'(w_msg), 64'(exp));
          check("cnt_0", 64'(cnt0), 64'(ecnt0[7:0]));
          check("cnt_1", 64'(cnt1), 64'(ecnt1[7:0]));
          check("wrap_cnt_1", 64'(w_cnt1), 64'(ecnt1[3:0]));
        end
        prev = o_req;
      end
    end
  end

  task automatic send(input int k, input logic [DSZ-1:0] dat);
    msg_t m;
    int t;
    m = mk(k, dat);
    if (k == 0) begin q0.push_back(m); m0 = m; req0 = 1'b1; end
    else        begin q1.push_back(m); m1 = m; req1 = 1'b1; end
    t = 0;
    while (((k == 0) ? ack0 : ack1) !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    check("ack_rise_timeout", 64'(t < 500), 64'd1);
    if (k == 0) begin acc0++; check("outstanding_0", 64'(acc0 - fwd0 <= 1), 64'd1); req0 = 1'b0; end
    else        begin acc1++; check("outstanding_1", 64'(acc1 - fwd1 <= 1), 64'd1); req1 = 1'b0; end
    t = 0;
    while (((k == 0) ? ack0 : ack1) !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    check("ack_fall_timeout", 64'(t < 500), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || o_req !== 1'b0 || o_ack) && t < 3000) begin
      @(negedge clk); t++;
    end
    check("drain_timeout", 64'(t < 3000), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete(); q1.delete(); log_q.delete();
    acc0 = 0; acc1 = 0; fwd0 = 0; fwd1 = 0; ecnt0 = 0; ecnt1 = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests held high; messages 5 and 9 form the first tie.
    m0 = mk(0, 16'd5); m1 = mk(1, 16'd9);
    q0.push_back(m0); q1.push_back(m1);
    req0 = 1'b1; req1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_oreq", 64'(o_req), 64'd0);
    check("rst_fields", 64'(o_msg), 64'd0);
    check("rst_cnt", 64'({cnt0, cnt1}), 64'd0);
    check("rst_wrap", 64'({w_ack0, w_ack1, w_req, w_cnt0, w_cnt1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ack0", 64'(ack0), 64'd1);
    check("rel_ack1", 64'(ack1), 64'd1);
    req0 = 1'b0; req1 = 1'b0;
    drain();
    check("tie_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("tie_first", 64'(log_q[0]), 64'd0);
      check("tie_second", 64'(log_q[1]), 64'd1);
    end

    // Single input stream.
    do_reset();
    sink_delay = 0;
    for (int i = 0; i < 16; i++) send(0, 16'(i));
    drain();
    check("single_cnt0", 64'(cnt0), 64'd16);
    check("single_cnt1", 64'(cnt1), 64'd0);
    check("single_wrap_cnt0", 64'(w_cnt0), 64'd0);

    // Continuous traffic from both: grants alternate.
    log_q.delete();
    sink_delay = 3;
    fork
      for (int i = 0; i < 8; i++) send(0, 16'(i));
      for (int j = 0; j < 8; j++) send(1, 16'(j + 100));
    join
    drain();
    check("alt_count", 64'(log_q.size()), 64'd16);
    for (int i = 1; i < log_q.size(); i++) check("alternate", 64'(log_q[i] != log_q[i-1]), 64'd1);

    // Back-pressure: slow sink, both sources stream.
    do_reset();
    sink_delay = 20;
    fork
      for (int i = 0; i < 16; i++) send(0, 16'(i));
      for (int j = 0; j < 16; j++) send(1, 16'(j));
    join
    drain();
    check("bp_fwd0", 64'(fwd0), 64'd16);
    check("bp_fwd1", 64'(fwd1), 64'd16);

    // Counter wrap on the 4-bit instance.
    do_reset();
    sink_delay = 0;
    for (int i = 0; i < 17; i++) send(1, 16'(i));
    drain();
    check("wrap_cnt1", 64'(w_cnt1), 64'd1);
    check("wrap_cnt0", 64'(w_cnt0), 64'd0);
    check("wide_cnt1", 64'(cnt1), 64'd17);

    // Reset while output busy and buffer 0 full.
    do_reset();
    sink_delay = 30;
    send(0, 16'd100);
    send(0, 16'd101);
    check("midrst_pre_oreq", 64'(o_req), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_oreq", 64'(o_req), 64'd0);
    check("midrst_acks", 64'({ack0, ack1}), 64'd0);
    check("midrst_cnt0", 64'(cnt0), 64'd0);
    q0.delete(); q1.delete(); log_q.delete();
    acc0 = 0; acc1 = 0; fwd0 = 0; fwd1 = 0; ecnt0 = 0; ecnt1 = 0;
    rst_n = 1'b1;
    sink_delay = 0;
    send(0, 16'd102);
    drain();
    repeat (5) @(negedge clk);
    check("midrst_fwd_count", 64'(log_q.size()), 64'd1);
    check("midrst_last_dat", 64'(o_msg.dat), 64'd102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
